// File: rtl/buffer_245_pkg.sv
// Shared constants for the 74x245-style bus transceiver.
package buffer_245_pkg;

   localparam logic DIR_B_TO_A = 1'b0;
   localparam logic DIR_A_TO_B = 1'b1;

   localparam int BUS_WIDTH_DEFAULT = 8;

endpackage : buffer_245_pkg

// File: rtl/buffer_245_tristate_driver.sv
// WIDTH-bit enable-gated tristate driver: passes din when en, floats otherwise.
module buffer_245_tristate_driver
   import buffer_245_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH_DEFAULT
) (
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output wire  [WIDTH-1:0] dout
);

   // Released lines are left floating; no bus hold on either side.
   assign dout = en ? din : {WIDTH{1'bz}};

endmodule : buffer_245_tristate_driver

// File: rtl/buffer_245.sv
// 8-bit bidirectional bus transceiver (74x245 behaviour) with a small
// clocked monitor that records the last transferred word and flags
// direction turnarounds.
module buffer_245
   import buffer_245_pkg::*;
#(
   parameter int WIDTH      = BUS_WIDTH_DEFAULT,
   parameter int PROP_DELAY = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dir,
   input  logic             noe,
   inout  wire  [WIDTH-1:0] a,
   inout  wire  [WIDTH-1:0] b,
   output logic             xfer_valid,
   output logic [WIDTH-1:0] xfer_data,
   output logic             xfer_dir,
   output logic             turnaround
);

   // PROP_DELAY is a timing annotation for gate-level style simulation only;
   // the RTL data path is modelled with zero delay.
   if (PROP_DELAY < 0) begin : g_prop_delay_unused
   end

   logic en_a2b;
   logic en_b2a;

   // At most one side is driven; both enables drop together when noe is high.
   assign en_a2b = ~noe & (dir == DIR_A_TO_B);
   assign en_b2a = ~noe & (dir == DIR_B_TO_A);

   buffer_245_tristate_driver #(.WIDTH(WIDTH)) u_drv_a2b (
      .en   (en_a2b),
      .din  (a),
      .dout (b)
   );

   buffer_245_tristate_driver #(.WIDTH(WIDTH)) u_drv_b2a (
      .en   (en_b2a),
      .din  (b),
      .dout (a)
   );

   logic             xfer_valid_q, xfer_valid_d;
   logic [WIDTH-1:0] xfer_data_q,  xfer_data_d;
   logic             xfer_dir_q,   xfer_dir_d;
   logic             turnaround_q, turnaround_d;
   logic             prev_valid_q, prev_valid_d;

   // Next-state for the monitor; disabled cycles keep data/dir and the
   // prev_valid history so a turnaround across a gap is still seen.
   always_comb begin
      xfer_valid_d = 1'b0;
      turnaround_d = 1'b0;
      xfer_data_d  = xfer_data_q;
      xfer_dir_d   = xfer_dir_q;
      prev_valid_d = prev_valid_q;
      if (!noe) begin
         xfer_valid_d = 1'b1;
         xfer_data_d  = (dir == DIR_A_TO_B) ? a : b;
         xfer_dir_d   = dir;
         turnaround_d = prev_valid_q & (xfer_dir_q != dir);
         prev_valid_d = 1'b1;
      end
   end

   // Monitor registers; reset clears only the monitor, never the data path.
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_valid_q <= 1'b0;
         xfer_data_q  <= '0;
         xfer_dir_q   <= 1'b0;
         turnaround_q <= 1'b0;
         prev_valid_q <= 1'b0;
      end else begin
         xfer_valid_q <= xfer_valid_d;
         xfer_data_q  <= xfer_data_d;
         xfer_dir_q   <= xfer_dir_d;
         turnaround_q <= turnaround_d;
         prev_valid_q <= prev_valid_d;
      end
   end

   assign xfer_valid = xfer_valid_q;
   assign xfer_data  = xfer_data_q;
   assign xfer_dir   = xfer_dir_q;
   assign turnaround = turnaround_q;

endmodule : buffer_245

// File: tb/tb_buffer_245.sv
// Bench for buffer_245: two instances split a 16-bit bus (low/high byte).
// Pull-ups on every bus line make an undriven (high-Z) line read as 1, so
// "DUT not driving" is observable as all-ones.
module tb_buffer_245;

   logic        clk = 1'b0;
   logic        reset;
   logic        dir;
   logic        noe;

   logic        tb_a_en, tb_b_en;
   logic [15:0] tb_a_val, tb_b_val;

   wire  [15:0] a_w;
   wire  [15:0] b_w;

   logic        lo_valid, hi_valid, lo_dir, hi_dir, lo_turn, hi_turn;
   logic [7:0]  lo_data, hi_data;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   assign a_w = tb_a_en ? tb_a_val : 16'hzzzz;
   assign b_w = tb_b_en ? tb_b_val : 16'hzzzz;

   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (a_w[i]);
      pullup (b_w[i]);
   end

   buffer_245 #(.WIDTH(8), .PROP_DELAY(0)) u_lo (
      .clk        (clk),
      .reset      (reset),
      .dir        (dir),
      .noe        (noe),
      .a          (a_w[7:0]),
      .b          (b_w[7:0]),
      .xfer_valid (lo_valid),
      .xfer_data  (lo_data),
      .xfer_dir   (lo_dir),
      .turnaround (lo_turn)
   );

   buffer_245 #(.WIDTH(8), .PROP_DELAY(0)) u_hi (
      .clk        (clk),
      .reset      (reset),
      .dir        (dir),
      .noe        (noe),
      .a          (a_w[15:8]),
      .b          (b_w[15:8]),
      .xfer_valid (hi_valid),
      .xfer_data  (hi_data),
      .xfer_dir   (hi_dir),
      .turnaround (hi_turn)
   );

   // Reference: a log of what an observer would remember about enabled transfers.
   bit          ref_valid;
   logic [15:0] ref_word;
   bit          ref_word_dir;
   bit          ref_turn;
   int          last_en_dir;  // -1 = no enabled transfer since reset

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One bus cycle: apply inputs, check the combinational bus, clock it,
   // advance the reference and check the monitor.
   task automatic step(input bit rst, input bit n_oe, input bit d,
                       input bit a_en, input bit b_en,
                       input logic [15:0] a_v, input logic [15:0] b_v);
      logic [15:0] exp_a, exp_b, src;
      @(negedge clk);
      reset    = rst;
      noe      = n_oe;
      dir      = d;
      tb_a_en  = a_en;
      tb_b_en  = b_en;
      tb_a_val = a_v;
      tb_b_val = b_v;
      #1;
      exp_a = a_en ? a_v : 16'hFFFF;
      exp_b = b_en ? b_v : 16'hFFFF;
      if (!n_oe) begin
         if (d) exp_b = exp_a;
         else   exp_a = exp_b;
      end
      check_val("bus_a", {16'h0, a_w}, {16'h0, exp_a});
      check_val("bus_b", {16'h0, b_w}, {16'h0, exp_b});
      src = d ? exp_a : exp_b;

      @(posedge clk);
      if (rst) begin
         ref_valid    = 0;
         ref_word     = 16'h0;
         ref_word_dir = 0;
         ref_turn     = 0;
         last_en_dir  = -1;
      end else if (n_oe) begin
         ref_valid = 0;
         ref_turn  = 0;
      end else begin
         ref_turn     = (last_en_dir != -1) && (last_en_dir != int'(d));
         last_en_dir  = int'(d);
         ref_valid    = 1;
         ref_word     = src;
         ref_word_dir = d;
      end
      #1;
      check_val("xfer_valid", {30'h0, hi_valid, lo_valid}, {30'h0, ref_valid, ref_valid});
      check_val("xfer_data",  {16'h0, hi_data, lo_data},   {16'h0, ref_word});
      check_val("xfer_dir",   {30'h0, hi_dir, lo_dir},     {30'h0, ref_word_dir, ref_word_dir});
      check_val("turnaround", {30'h0, hi_turn, lo_turn},   {30'h0, ref_turn, ref_turn});
   endtask

   initial begin
      reset = 1'b1; noe = 1'b1; dir = 1'b0;
      tb_a_en = 1'b0; tb_b_en = 1'b0; tb_a_val = '0; tb_b_val = '0;
      ref_valid = 0; ref_word = '0; ref_word_dir = 0; ref_turn = 0; last_en_dir = -1;

      // reset state
      step(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
      // A->B
      step(0, 0, 1, 1, 0, 16'h00A5, 16'h0000);
      // B->A
      step(0, 0, 0, 0, 1, 16'h0000, 16'h003C);
      // disabled, nobody driving, both dir values: lines float (pulled to 1)
      step(0, 1, 1, 0, 0, 16'h0000, 16'h0000);
      step(0, 1, 0, 0, 0, 16'h0000, 16'h0000);
      // disabled with one side driven low: the other side must stay released
      step(0, 1, 1, 1, 0, 16'h0000, 16'h0000);
      step(0, 1, 0, 0, 1, 16'h0000, 16'h0000);
      // turnaround across a disabled gap, then a single-cycle pulse
      step(0, 0, 1, 1, 0, 16'h1111, 16'h0000);
      step(0, 1, 1, 0, 0, 16'h0000, 16'h0000);
      step(0, 0, 0, 0, 1, 16'h0000, 16'h2222);
      step(0, 0, 0, 0, 1, 16'h0000, 16'h3333);
      // reset while holding FF, data path keeps working under reset
      step(0, 0, 1, 1, 0, 16'hFFFF, 16'h0000);
      step(1, 0, 1, 1, 0, 16'h0012, 16'h0000);
      // no turnaround right after reset even though dir changes
      step(0, 0, 0, 0, 1, 16'h0000, 16'h0055);
      // split 16-bit use
      step(0, 0, 1, 1, 0, 16'h1234, 16'h0000);
      step(0, 0, 0, 0, 1, 16'h0000, 16'hBEEF);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         bit          r_rst, r_noe, r_dir, r_aen, r_ben;
         int unsigned sel;
         logic [15:0] r_a, r_b;
         r_rst = ($urandom_range(0, 19) == 0);
         r_noe = ($urandom_range(0, 2) == 0);
         r_dir = 1'($urandom_range(0, 1));
         r_a   = 16'($urandom);
         r_b   = 16'($urandom);
         if (!r_noe) begin
            r_aen = r_dir;
            r_ben = !r_dir;
         end else begin
            sel   = $urandom_range(0, 2);
            r_aen = (sel == 1);
            r_ben = (sel == 2);
         end
         step(r_rst, r_noe, r_dir, r_aen, r_ben, r_a, r_b);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_buffer_245
